// File: rtl/omem_acc_arbiter.sv
// Owns the single OutputMemory port: buffers array result rows, overwrites or read-modify-write
// accumulates them, and shares the port with host read-out under a starvation guard.
module omem_acc_arbiter #(
    parameter int LANES      = 4,
    parameter int LANE_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    Start,
    input  logic                    ACC_VALID,
    output logic                    ACC_READY,
    input  logic [LANES*LANE_W-1:0] ACC_DATA,
    input  logic [1:0]              ACC_ROW,
    input  logic [3:0]              ODST,
    input  logic                    ACC_FIRST,
    output logic                    WB_DONE,
    input  logic                    HOST_REQ,
    input  logic [5:0]              HOST_ADDR,
    output logic                    HOST_GNT,
    output logic                    HOST_RVALID,
    output logic [LANES*LANE_W-1:0] HOST_RDATA,
    output logic                    MEM_EN,
    output logic                    MEM_WE,
    output logic [5:0]              MEM_ADDR,
    output logic [LANES*LANE_W-1:0] MEM_WDATA,
    input  logic [LANES*LANE_W-1:0] MEM_RDATA
);
    localparam int WORD_W   = LANES * LANE_W;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_IDLE,
        ST_RMW_WR
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [5:0]        addr;
        logic              first;
    } entry_t;

    state_t              state, next_state;
    entry_t              fifo_mem [FIFO_DEPTH];
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [STARVE_W-1:0] starve_cnt;
    logic [WORD_W-1:0]   rmw_data;
    logic [5:0]          rmw_addr;
    logic [WORD_W-1:0]   rmw_sum;
    logic                fifo_empty;
    logic                host_win;
    logic                push, pop, latch_rmw, wr_row3;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness comes from the registered count only, so a same-cycle pop never reopens a full FIFO.
    assign ACC_READY  = (count < CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = ACC_VALID && ACC_READY && !Start;
    assign head       = fifo_mem[rd_ptr];
    assign host_win   = HOST_REQ && (fifo_empty || starve_cnt == STARVE_W'(STARVE_MAX));
    assign HOST_RDATA = HOST_RVALID ? MEM_RDATA : '0;

    // NOTE: row storage has no reset; validity is tracked entirely by count/pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{data: ACC_DATA, addr: {ODST, ACC_ROW}, first: ACC_FIRST};
        end
    end

    // Lane-wise wrap-around add; each lane truncates independently so no carry crosses lanes.
    always_comb begin
        rmw_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            rmw_sum[k*LANE_W +: LANE_W] = MEM_RDATA[k*LANE_W +: LANE_W] + rmw_data[k*LANE_W +: LANE_W];
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        next_state = state;
        HOST_GNT   = 1'b0;
        MEM_EN     = 1'b0;
        MEM_WE     = 1'b0;
        MEM_ADDR   = '0;
        MEM_WDATA  = '0;
        pop        = 1'b0;
        latch_rmw  = 1'b0;
        wr_row3    = 1'b0;
        if (Start) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host_win) begin
                        HOST_GNT = 1'b1;
                        MEM_EN   = 1'b1;
                        MEM_ADDR = HOST_ADDR;
                    end else if (!fifo_empty) begin
                        MEM_EN   = 1'b1;
                        MEM_ADDR = head.addr;
                        pop      = 1'b1;
                        if (head.first) begin
                            MEM_WE    = 1'b1;
                            MEM_WDATA = head.data;
                            wr_row3   = (head.addr[1:0] == 2'd3);
                        end else begin
                            latch_rmw  = 1'b1;
                            next_state = ST_RMW_WR;
                        end
                    end
                end
                ST_RMW_WR: begin
                    MEM_EN     = 1'b1;
                    MEM_WE     = 1'b1;
                    MEM_ADDR   = rmw_addr;
                    MEM_WDATA  = rmw_sum;
                    wr_row3    = (rmw_addr[1:0] == 2'd3);
                    next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            starve_cnt  <= '0;
            rmw_data    <= '0;
            rmw_addr    <= '0;
            WB_DONE     <= 1'b0;
            HOST_RVALID <= 1'b0;
        end else if (Start) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            starve_cnt  <= '0;
            WB_DONE     <= 1'b0;
            HOST_RVALID <= 1'b0;
        end else begin
            state       <= next_state;
            WB_DONE     <= wr_row3;
            HOST_RVALID <= HOST_GNT;
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (latch_rmw) begin
                rmw_data <= head.data;
                rmw_addr <= head.addr;
            end
            // Only denied IDLE cycles age the host; RMW_WR cycles are not arbitration cycles.
            if (HOST_GNT) begin
                starve_cnt <= '0;
            end else if (state == ST_IDLE && HOST_REQ && starve_cnt != STARVE_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_omem_acc_arbiter.sv
// Directed bench for omem_acc_arbiter: a behavioural OutputMemory logs every port access,
// and each scenario compares the log and sampled outputs against hand-computed values.
module tb_omem_acc_arbiter;
    logic        CLK = 1'b0;
    logic        RSTN;
    logic        Start;
    logic        ACC_VALID;
    logic        ACC_READY;
    logic [63:0] ACC_DATA;
    logic [1:0]  ACC_ROW;
    logic [3:0]  ODST;
    logic        ACC_FIRST;
    logic        WB_DONE;
    logic        HOST_REQ;
    logic [5:0]  HOST_ADDR;
    logic        HOST_GNT;
    logic        HOST_RVALID;
    logic [63:0] HOST_RDATA;
    logic        MEM_EN;
    logic        MEM_WE;
    logic [5:0]  MEM_ADDR;
    logic [63:0] MEM_WDATA;
    logic [63:0] MEM_RDATA;

    typedef struct {
        int          cyc;
        logic        we;
        logic [5:0]  addr;
        logic [63:0] wdata;
    } acc_t;

    logic [63:0] mem [64];
    logic [63:0] rdata_q;
    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [63:0] pre_data = '0;
    int          cyc = 0;
    acc_t        acc_q[$];
    int          wb_q[$];
    acc_t        wr[$];
    int          n_checks = 0;
    int          n_fail = 0;

    omem_acc_arbiter dut (
        .CLK(CLK), .RSTN(RSTN), .Start(Start),
        .ACC_VALID(ACC_VALID), .ACC_READY(ACC_READY), .ACC_DATA(ACC_DATA),
        .ACC_ROW(ACC_ROW), .ODST(ODST), .ACC_FIRST(ACC_FIRST), .WB_DONE(WB_DONE),
        .HOST_REQ(HOST_REQ), .HOST_ADDR(HOST_ADDR), .HOST_GNT(HOST_GNT),
        .HOST_RVALID(HOST_RVALID), .HOST_RDATA(HOST_RDATA),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    assign MEM_RDATA = rdata_q;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (MEM_EN) begin
            acc_q.push_back('{cyc, MEM_WE, MEM_ADDR, MEM_WDATA});
            if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
            else        rdata_q <= mem[MEM_ADDR];
        end
        if (WB_DONE) wb_q.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [63:0] d);
        @(negedge CLK);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge CLK);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic drive_row(input logic [3:0] dst, input logic [1:0] row, input logic first,
                             input logic [63:0] data);
        ACC_VALID = 1'b1;
        ODST      = dst;
        ACC_ROW   = row;
        ACC_FIRST = first;
        ACC_DATA  = data;
    endtask

    task automatic collect_writes(input int base);
        wr.delete();
        for (int i = base; i < acc_q.size(); i++) begin
            if (acc_q[i].we) wr.push_back(acc_q[i]);
        end
    endtask

    initial begin
        int          base, wb_base, idx, first_low, guard, denied;
        bit          granted;
        logic [15:0] l;
        logic [63:0] exp_d;

        RSTN = 1'b0; Start = 1'b0; ACC_VALID = 1'b0; ACC_DATA = '0; ACC_ROW = '0;
        ODST = '0; ACC_FIRST = 1'b0; HOST_REQ = 1'b0; HOST_ADDR = '0;
        #1;
        check("rst_in_ready", ACC_READY, 1);
        check("rst_in_mem_en", MEM_EN, 0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;

        for (int a = 0; a < 64; a++) preload(6'(a), 64'h0);
        preload(6'd7, 64'hDEAD_BEEF_0123_4567);
        preload(6'd8, 64'h0001_0002_0003_0004);

        @(negedge CLK); #1;
        check("rst_ready", ACC_READY, 1);
        check("rst_mem_en", MEM_EN, 0);
        check("rst_mem_we", MEM_WE, 0);
        check("rst_mem_addr", MEM_ADDR, 0);
        check("rst_mem_wdata", MEM_WDATA, 0);
        check("rst_wb_done", WB_DONE, 0);
        check("rst_host_gnt", HOST_GNT, 0);
        check("rst_host_rvalid", HOST_RVALID, 0);
        check("rst_host_rdata", HOST_RDATA, 0);

        // First-pass tile ODST=5: four overwrites on consecutive cycles, then WB_DONE.
        base = acc_q.size(); wb_base = wb_q.size();
        for (int r = 0; r < 4; r++) begin
            @(negedge CLK);
            l = 16'(r);
            drive_row(4'd5, 2'(r), 1'b1, {16'hA000 + l, 16'hB000 + l, 16'hC000 + l, 16'hD000 + l});
        end
        @(negedge CLK); ACC_VALID = 1'b0;
        repeat (6) @(negedge CLK);
        collect_writes(base);
        check("t1_nacc", acc_q.size() - base, 4);
        check("t1_nwr", wr.size(), 4);
        if (wr.size() == 4) begin
            for (int r = 0; r < 4; r++) begin
                l = 16'(r);
                check("t1_addr", wr[r].addr, 6'(20 + r));
                check("t1_data", wr[r].wdata, {16'hA000 + l, 16'hB000 + l, 16'hC000 + l, 16'hD000 + l});
                if (r > 0) check("t1_b2b", wr[r].cyc - wr[r-1].cyc, 1);
            end
            check("t1_nwb", wb_q.size() - wb_base, 1);
            if (wb_q.size() - wb_base == 1) check("t1_wb_cyc", wb_q[wb_base], wr[3].cyc + 1);
        end

        // Host read on an empty FIFO: same-cycle grant, data the following cycle.
        @(negedge CLK);
        HOST_REQ = 1'b1; HOST_ADDR = 6'd7; #1;
        check("t4_gnt", HOST_GNT, 1);
        check("t4_mem_en", MEM_EN, 1);
        check("t4_mem_we", MEM_WE, 0);
        check("t4_mem_addr", MEM_ADDR, 7);
        @(negedge CLK);
        HOST_REQ = 1'b0; #1;
        check("t4_rvalid", HOST_RVALID, 1);
        check("t4_rdata", HOST_RDATA, 64'hDEAD_BEEF_0123_4567);
        @(negedge CLK); #1;
        check("t4_rvalid_drop", HOST_RVALID, 0);

        // Accumulate: one saturating-looking lane and one wrapping lane.
        preload(6'd20, 64'h7FFF_0003_0002_0001);
        preload(6'd21, 64'h0000_0000_0005_FFFF);
        base = acc_q.size();
        @(negedge CLK); drive_row(4'd5, 2'd0, 1'b0, 64'h0001_0001_0001_0001);
        @(negedge CLK); drive_row(4'd5, 2'd1, 1'b0, 64'h0000_0000_0000_0001);
        @(negedge CLK); ACC_VALID = 1'b0;
        repeat (6) @(negedge CLK);
        check("t2_nacc", acc_q.size() - base, 4);
        if (acc_q.size() - base == 4) begin
            check("t2_rd_we", acc_q[base].we, 0);
            check("t2_rd_addr", acc_q[base].addr, 20);
            check("t2_wr_we", acc_q[base+1].we, 1);
            check("t2_wr_addr", acc_q[base+1].addr, 20);
            check("t2_wr_data", acc_q[base+1].wdata, 64'h8000_0004_0003_0002);
            check("t2_rmw_gap", acc_q[base+1].cyc - acc_q[base].cyc, 1);
            check("t2_wrap_addr", acc_q[base+3].addr, 21);
            check("t2_wrap_data", acc_q[base+3].wdata, 64'h0000_0000_0005_0000);
        end

        // Backpressure: 8 accumulate rows pushed continuously; the FIFO gains one entry every
        // two cycles, so it first reads full with 7 accepted, while a pop is in flight.
        base = acc_q.size(); wb_base = wb_q.size();
        idx = 0; first_low = -1; guard = 0;
        while (idx < 8 && guard < 40) begin
            @(negedge CLK);
            l = 16'h0100 + 16'(idx);
            drive_row((idx < 4) ? 4'd2 : 4'd3, 2'(idx), 1'b0, {4{l}});
            #1;
            if (ACC_READY) begin
                idx++;
            end else if (first_low < 0) begin
                first_low = idx;
                check("t3_full_pop_en", MEM_EN, 1);
                check("t3_full_pop_we", MEM_WE, 0);
            end
            guard++;
        end
        check("t3_all_pushed", idx, 8);
        check("t3_first_low", first_low, 7);
        @(negedge CLK); ACC_VALID = 1'b0;
        repeat (20) @(negedge CLK);
        collect_writes(base);
        check("t3_nwr", wr.size(), 8);
        if (wr.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                l = 16'h0100 + 16'(i);
                exp_d = (i == 0) ? 64'h0101_0102_0103_0104 : {4{l}};
                check("t3_addr", wr[i].addr, 6'(8 + i));
                check("t3_data", wr[i].wdata, exp_d);
                if (i > 0) check("t3_cadence", wr[i].cyc - wr[i-1].cyc, 2);
            end
        end
        check("t3_nwb", wb_q.size() - wb_base, 2);

        // Starvation: FIFO never empty, host must wait exactly 8 denied cycles, twice.
        @(negedge CLK); drive_row(4'd4, 2'd0, 1'b1, 64'h5555_5555_5555_5555);
        for (int round = 0; round < 2; round++) begin
            denied = 0; granted = 1'b0;
            for (int i = 0; i < 20 && !granted; i++) begin
                @(negedge CLK);
                drive_row(4'd4, 2'(i), 1'b1, 64'h5555_5555_5555_5555);
                HOST_REQ = 1'b1; HOST_ADDR = 6'd7; #1;
                if (HOST_GNT) begin
                    granted = 1'b1;
                    check("t5_gnt_we", MEM_WE, 0);
                    check("t5_gnt_addr", MEM_ADDR, 7);
                end else begin
                    denied++;
                end
            end
            check("t5_granted", granted, 1);
            check("t5_denied", denied, 8);
            @(negedge CLK);
            HOST_REQ = 1'b0;
            drive_row(4'd4, 2'd1, 1'b1, 64'h5555_5555_5555_5555); #1;
            check("t5_rvalid", HOST_RVALID, 1);
            check("t5_rdata", HOST_RDATA, 64'hDEAD_BEEF_0123_4567);
        end
        @(negedge CLK); ACC_VALID = 1'b0;
        repeat (8) @(negedge CLK);

        // Start during RMW_WR of a row-3 entry with two more entries queued.
        wb_base = wb_q.size();
        @(negedge CLK); drive_row(4'd6, 2'd0, 1'b0, 64'h0000_0000_0000_0011);
        @(negedge CLK); drive_row(4'd6, 2'd3, 1'b0, 64'h0000_0000_0000_0022);
        @(negedge CLK); drive_row(4'd7, 2'd3, 1'b0, 64'h0000_0000_0000_0033);
        @(negedge CLK); drive_row(4'd7, 2'd0, 1'b0, 64'h0000_0000_0000_0044);
        @(negedge CLK);
        base = acc_q.size();
        Start = 1'b1;
        drive_row(4'd8, 2'd3, 1'b1, 64'h0000_0000_0000_0055); #1;
        check("t6_start_mem_en", MEM_EN, 0);
        check("t6_last_rd_addr", acc_q[base-1].addr, 27);
        check("t6_last_rd_we", acc_q[base-1].we, 0);
        @(negedge CLK);
        Start = 1'b0; ACC_VALID = 1'b0; #1;
        check("t6_ready", ACC_READY, 1);
        check("t6_mem_en", MEM_EN, 0);
        check("t6_rvalid", HOST_RVALID, 0);
        repeat (8) @(negedge CLK);
        check("t6_no_access", acc_q.size() - base, 0);
        check("t6_no_wb", wb_q.size() - wb_base, 0);

        // Asynchronous reset in the middle of an RMW write.
        @(negedge CLK); drive_row(4'd9, 2'd0, 1'b0, 64'h1);
        @(negedge CLK); drive_row(4'd9, 2'd1, 1'b0, 64'h2);
        @(negedge CLK); ACC_VALID = 1'b0; #1;
        check("rst_mid_pre_en", MEM_EN, 1);
        RSTN = 1'b0; #1;
        check("rst_mid_mem_en", MEM_EN, 0);
        check("rst_mid_ready", ACC_READY, 1);
        check("rst_mid_wb", WB_DONE, 0);
        @(negedge CLK); RSTN = 1'b1;
        @(negedge CLK); #1;
        check("rst_mid_flushed", MEM_EN, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
